// File: rtl/msg_block_padder_pkg.sv
// -----------------------------------------------------------------------------
// msg_block_padder_pkg
// Shared widths, the end-of-message marker default and the padder FSM state
// type. Imported by the interface, the word padder and the top.
// -----------------------------------------------------------------------------
package msg_block_padder_pkg;

  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 128;
  localparam int LEN_W   = 32;

  localparam logic [7:0] PAD_BYTE_DEFAULT = 8'h80;

  typedef enum logic [1:0] {
    S_ACCUM    = 2'd0,
    S_OUT      = 2'd1,
    S_OUT_TAIL = 2'd2
  } pad_state_e;

endpackage

// File: rtl/msg_block_padder_if.sv
// -----------------------------------------------------------------------------
// msg_block_padder_if
// Word-in / block-out stream bundle for the padder.
//   in_valid/in_ready/in_data/in_last/in_nbytes : 32-bit message words in
//   out_valid/out_ready/out_data/out_last       : 128-bit padded blocks out
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. The source keeps valid and its payload stable until that edge;
// ready may change freely and never depends on valid.
// master = message source + block sink, slave = the padder.
// -----------------------------------------------------------------------------
interface msg_block_padder_if
  import msg_block_padder_pkg::*;
();

  logic               in_valid;
  logic               in_ready;
  logic [WORD_W-1:0]  in_data;
  logic               in_last;
  logic [1:0]         in_nbytes;

  logic               out_valid;
  logic               out_ready;
  logic [BLOCK_W-1:0] out_data;
  logic               out_last;

  modport master (
    output in_valid, in_data, in_last, in_nbytes, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_nbytes, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/msg_pad_word.sv
// -----------------------------------------------------------------------------
// msg_pad_word
// Combinational formatting of a final message word: keeps the top k valid
// bytes, writes the marker into byte k and zeroes the rest. nbytes 0 means
// all four bytes are valid; the word then passes through unchanged and
// full_o tells the caller the marker has to go into the following slot.
//   word_i   : raw final word (byte0 = [31:24])
//   nbytes_i : valid bytes, 0 encodes 4
//   word_o   : masked word with marker
//   full_o   : word had 4 valid bytes
// -----------------------------------------------------------------------------
module msg_pad_word
  import msg_block_padder_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = PAD_BYTE_DEFAULT
) (
  input  logic [WORD_W-1:0] word_i,
  input  logic [1:0]        nbytes_i,
  output logic [WORD_W-1:0] word_o,
  output logic              full_o
);

  always_comb begin
    full_o = (nbytes_i == 2'd0);
    word_o = '0;
    for (int b = 0; b < 4; b++) begin
      if (full_o || (2'(b) < nbytes_i)) begin
        word_o[WORD_W-1-8*b -: 8] = word_i[WORD_W-1-8*b -: 8];
      end else if (2'(b) == nbytes_i) begin
        word_o[WORD_W-1-8*b -: 8] = PAD_BYTE;
      end
    end
  end

endmodule

// File: rtl/msg_block_padder.sv
// -----------------------------------------------------------------------------
// msg_block_padder
// Packs 32-bit message words into 128-bit blocks, appends the end-of-message
// marker, zero fill and the 32-bit bit length in word3 of the final block.
// When the marker leaves no room for the length, an extra tail block
// {T,0,0,len} follows back-to-back.
//   clk, rst : clock, synchronous active-high reset
//   bus      : msg_block_padder_if.slave (word stream in, block stream out)
//   state_o  : current FSM state, for observation only
// -----------------------------------------------------------------------------
module msg_block_padder
  import msg_block_padder_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = PAD_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  msg_block_padder_if.slave bus,
  output pad_state_e        state_o
);

  localparam logic [WORD_W-1:0] MARKER_WORD = {PAD_BYTE, {(WORD_W-8){1'b0}}};

  pad_state_e         state_q;
  logic [1:0]         slot_q;
  logic [LEN_W-1:0]   len_q;
  logic [WORD_W-1:0]  acc_q [3];
  logic [BLOCK_W-1:0] out_data_q;
  logic               out_valid_q;
  logic               out_last_q;
  logic               tail_mark_q;

  logic               in_fire;
  logic [2:0]         k_bytes;
  logic [LEN_W-1:0]   len_d;
  logic [WORD_W-1:0]  pad_word;
  logic               pad_full;
  logic [WORD_W-1:0]  blk_w [4];
  logic [BLOCK_W-1:0] block_d;
  logic               need_tail;
  logic               tail_mark_d;
  logic [WORD_W-1:0]  tail_word;

  msg_pad_word #(.PAD_BYTE(PAD_BYTE)) u_pad_word (
    .word_i   (bus.in_data),
    .nbytes_i (bus.in_nbytes),
    .word_o   (pad_word),
    .full_o   (pad_full)
  );

  assign bus.in_ready  = (state_q == S_ACCUM) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign state_o       = state_q;

  assign in_fire   = bus.in_valid && bus.in_ready;
  assign k_bytes   = (bus.in_nbytes == 2'd0) ? 3'd4 : {1'b0, bus.in_nbytes};
  // Non-last words always carry 4 bytes; in_nbytes only matters on the last.
  assign len_d     = len_q + (bus.in_last ? {{(LEN_W-6){1'b0}}, k_bytes, 3'b000}
                                          : LEN_W'(32));
  assign tail_word = tail_mark_q ? MARKER_WORD : '0;

  // Block assembled from the stored slots plus the word being accepted.
  // Slots at or beyond the current one start out zero.
  always_comb begin
    need_tail   = 1'b0;
    tail_mark_d = 1'b0;
    for (int i = 0; i < 4; i++) blk_w[i] = '0;
    for (int i = 0; i < 3; i++) begin
      if (2'(i) < slot_q) blk_w[i] = acc_q[i];
    end
    if (!bus.in_last) begin
      // Only consumed when this 4th word completes the block.
      blk_w[3] = bus.in_data;
    end else begin
      blk_w[slot_q] = pad_word;
      if (pad_full) begin
        case (slot_q)
          2'd3: begin
            // Marker spills into the next block.
            need_tail   = 1'b1;
            tail_mark_d = 1'b1;
          end
          2'd2: begin
            // Marker takes word3, length moves to the tail.
            blk_w[3]  = MARKER_WORD;
            need_tail = 1'b1;
          end
          default: begin
            blk_w[slot_q + 2'd1] = MARKER_WORD;
            blk_w[3]             = len_d;
          end
        endcase
      end else if (slot_q == 2'd3) begin
        need_tail = 1'b1;
      end else begin
        blk_w[3] = len_d;
      end
    end
    block_d = {blk_w[0], blk_w[1], blk_w[2], blk_w[3]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_ACCUM;
      slot_q      <= '0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      tail_mark_q <= 1'b0;
      for (int i = 0; i < 3; i++) acc_q[i] <= '0;
    end else begin
      case (state_q)
        S_ACCUM: begin
          if (in_fire) begin
            len_q  <= len_d;
            slot_q <= slot_q + 2'd1;
            if (bus.in_last || (slot_q == 2'd3)) begin
              out_data_q  <= block_d;
              out_valid_q <= 1'b1;
              out_last_q  <= bus.in_last && !need_tail;
              tail_mark_q <= tail_mark_d;
              state_q     <= (bus.in_last && need_tail) ? S_OUT_TAIL : S_OUT;
            end else begin
              acc_q[slot_q] <= bus.in_data;
            end
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_ACCUM;
            if (out_last_q) begin
              // Message finished: next word starts a fresh message.
              slot_q <= '0;
              len_q  <= '0;
            end
          end
        end
        S_OUT_TAIL: begin
          if (bus.out_ready) begin
            out_data_q <= {tail_word, {(2*WORD_W){1'b0}}, len_q};
            out_last_q <= 1'b1;
            state_q    <= S_OUT;
          end
        end
        default: state_q <= S_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_block_padder.sv
// -----------------------------------------------------------------------------
// tb_msg_block_padder
// Bench for msg_block_padder. Expected blocks come from a byte-level model:
// message bytes, one marker byte, zero fill up to 12 mod 16, then the 32-bit
// big-endian bit count, cut into 16-byte blocks (last one flagged).
// -----------------------------------------------------------------------------
module tb_msg_block_padder;
  import msg_block_padder_pkg::*;

  localparam logic [7:0] PAD = 8'h80;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  msg_block_padder_if bus();
  pad_state_e state_o;

  msg_block_padder #(.PAD_BYTE(PAD)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_o)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
  int gap_max  = 0;

  logic [BLOCK_W:0] exp_q[$];
  logic [BLOCK_W:0] got_q[$];
  int               got_cyc_q[$];
  logic [31:0]      msg_words[$];
  logic [1:0]       msg_nb;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- clock/reset-side drivers ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.in_nbytes = '0;
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Block monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        got_q.push_back({bus.out_last, bus.out_data});
        got_cyc_q.push_back(cyc);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [31:0] d, input bit last,
                           input logic [1:0] nb, output bit ok);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_last   = last;
    bus.in_nbytes = nb;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_words(output bit ok);
    bit a;
    ok = 1'b1;
    for (int i = 0; i < msg_words.size(); i++) begin
      bit last;
      last = (i == msg_words.size() - 1);
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk);
        #1;
      end
      send_word(msg_words[i], last, last ? msg_nb : 2'($urandom), a);
      if (!a) ok = 1'b0;
    end
  endtask

  task automatic wait_blocks(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (got_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic flush_queues();
    exp_q.delete();
    got_q.delete();
    got_cyc_q.delete();
  endtask

  // ---------------- reference model ----------------
  task automatic model_msg();
    logic [7:0]         b[$];
    logic [31:0]        bits;
    logic [BLOCK_W-1:0] d;
    int                 nblk;
    for (int i = 0; i < msg_words.size(); i++) begin
      int n;
      n = (i == msg_words.size() - 1) ? ((msg_nb == 2'd0) ? 4 : int'(msg_nb)) : 4;
      for (int j = 0; j < n; j++) b.push_back(msg_words[i][31-8*j -: 8]);
    end
    bits = 32'(b.size() * 8);
    b.push_back(PAD);
    while ((b.size() % 16) != 12) b.push_back(8'h00);
    for (int j = 0; j < 4; j++) b.push_back(bits[31-8*j -: 8]);
    nblk = b.size() / 16;
    for (int k = 0; k < nblk; k++) begin
      d = '0;
      for (int j = 0; j < 16; j++) d[127-8*j -: 8] = b[16*k+j];
      exp_q.push_back({(k == nblk - 1), d});
    end
  endtask

  // Model-driven message: send, collect, compare every block.
  task automatic run_msg(input string name);
    bit ok;
    logic [BLOCK_W:0] e, g;
    int idx;
    flush_queues();
    model_msg();
    send_words(ok);
    if (!ok) begin
      total++; bad++;
      $display("FAIL %s: word not accepted within bound", name);
    end
    wait_blocks(exp_q.size(), ok);
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (got_q.size() == 0) begin
        bad++;
        $display("FAIL %s blk%0d: got no block, required last=%0b data=%h",
                 name, idx, e[BLOCK_W], e[BLOCK_W-1:0]);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          bad++;
          $display("FAIL %s blk%0d: got last=%0b data=%h, required last=%0b data=%h",
                   name, idx, g[BLOCK_W], g[BLOCK_W-1:0], e[BLOCK_W], e[BLOCK_W-1:0]);
        end
      end
      idx++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %0b required 0", bus.in_ready); end
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %0b required 0", bus.out_valid); end
    total++;
    if (bus.out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last: got %0b required 0", bus.out_last); end
    total++;
    if (bus.out_data !== '0) begin bad++; $display("FAIL rst_out_data: got %h required 0", bus.out_data); end
    total++;
    if (state_o !== S_ACCUM) begin bad++; $display("FAIL rst_state: got %0d required %0d", state_o, S_ACCUM); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready: got %0b required 1", bus.in_ready); end
  endtask

  task automatic test_single_partial();
    bit ok;
    logic [BLOCK_W:0] g;
    rdy_mode = 0;
    flush_queues();
    send_word(32'hDEADBEEF, 1'b1, 2'd2, ok);
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL latency: out_valid got %0b required 1", bus.out_valid); end
    wait_blocks(1, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL single_partial: got no block, required 1");
    end else begin
      g = got_q.pop_front();
      if (g !== {1'b1, 128'hDEAD8000_00000000_00000000_00000010}) begin
        bad++; $display("FAIL single_partial: got last=%0b data=%h required last=1 data=dead8000000000000000000000000010",
                        g[BLOCK_W], g[BLOCK_W-1:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [31:0] w [3];
    logic [BLOCK_W:0] g0, g1;
    rdy_mode = 0;
    flush_queues();
    for (int i = 0; i < 3; i++) begin
      w[i] = $urandom;
      send_word(w[i], i == 2, 2'd0, ok);
    end
    wait_blocks(2, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL back_to_back: got %0d blocks required 2", got_q.size());
    end else begin
      g0 = got_q.pop_front();
      g1 = got_q.pop_front();
      if (g0 !== {1'b0, w[0], w[1], w[2], 32'h80000000}) begin
        bad++; $display("FAIL b2b_blk0: got last=%0b data=%h required last=0 data=%h%h%h80000000",
                        g0[BLOCK_W], g0[BLOCK_W-1:0], w[0], w[1], w[2]);
      end
      total++;
      if (g1 !== {1'b1, 96'h0, 32'h00000060}) begin
        bad++; $display("FAIL b2b_blk1: got last=%0b data=%h required last=1 data=...00000060",
                        g1[BLOCK_W], g1[BLOCK_W-1:0]);
      end
      total++;
      if (got_cyc_q[1] - got_cyc_q[0] !== 1) begin
        bad++; $display("FAIL b2b_gap: got %0d cycles required 1", got_cyc_q[1] - got_cyc_q[0]);
      end
    end
  endtask

  task automatic test_slot3_partial();
    bit ok;
    logic [31:0] w [3];
    logic [BLOCK_W:0] g0, g1;
    rdy_mode = 0;
    flush_queues();
    for (int i = 0; i < 3; i++) begin
      w[i] = $urandom;
      send_word(w[i], 1'b0, 2'($urandom), ok);
    end
    send_word(32'h11223344, 1'b1, 2'd1, ok);
    wait_blocks(2, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL slot3_partial: got %0d blocks required 2", got_q.size());
    end else begin
      g0 = got_q.pop_front();
      g1 = got_q.pop_front();
      if (g0 !== {1'b0, w[0], w[1], w[2], 32'h11800000}) begin
        bad++; $display("FAIL s3p_blk0: got last=%0b data=%h required last=0 data=%h%h%h11800000",
                        g0[BLOCK_W], g0[BLOCK_W-1:0], w[0], w[1], w[2]);
      end
      total++;
      if (g1 !== {1'b1, 96'h0, 32'h00000068}) begin
        bad++; $display("FAIL s3p_blk1: got last=%0b data=%h required last=1 data=...00000068",
                        g1[BLOCK_W], g1[BLOCK_W-1:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [BLOCK_W-1:0] hold_d;
    logic               hold_l;
    logic [BLOCK_W:0]   e, g;
    rdy_mode = 2;
    flush_queues();
    msg_words.delete();
    for (int i = 0; i < 3; i++) msg_words.push_back($urandom);
    msg_words.push_back(32'hA1B2C3D4);
    msg_nb = 2'd2;
    model_msg();
    for (int i = 0; i < 4; i++) send_word(msg_words[i], i == 3, (i == 3) ? msg_nb : 2'd0, ok);
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %0b required 1", bus.out_valid); end
    hold_d = bus.out_data;
    hold_l = bus.out_last;
    bus.in_valid = 1'b1;
    bus.in_data  = $urandom;
    bus.in_last  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (bus.out_data !== hold_d) begin bad++; $display("FAIL bp_data c%0d: got %h required %h", c, bus.out_data, hold_d); end
      total++;
      if (bus.out_last !== hold_l) begin bad++; $display("FAIL bp_last c%0d: got %0b required %0b", c, bus.out_last, hold_l); end
      total++;
      if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready c%0d: got %0b required 0", c, bus.in_ready); end
    end
    bus.in_valid = 1'b0;
    rdy_mode = 0;
    wait_blocks(exp_q.size(), ok);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (got_q.size() == 0) begin
        bad++; $display("FAIL bp_drain: got no block, required data=%h", e[BLOCK_W-1:0]);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          bad++; $display("FAIL bp_drain: got last=%0b data=%h required last=%0b data=%h",
                          g[BLOCK_W], g[BLOCK_W-1:0], e[BLOCK_W], e[BLOCK_W-1:0]);
        end
      end
    end
  endtask

  task automatic test_reset_midmsg();
    bit ok;
    logic [BLOCK_W:0] g;
    rdy_mode = 0;
    send_word($urandom, 1'b0, 2'd0, ok);
    send_word($urandom, 1'b0, 2'd0, ok);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL midrst_in_ready: got %0b required 0", bus.in_ready); end
    @(posedge clk);
    #1 rst = 1'b0;
    flush_queues();
    send_word(32'hCAFEF00D, 1'b1, 2'd0, ok);
    wait_blocks(1, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL reset_midmsg: got no block, required 1");
    end else begin
      g = got_q.pop_front();
      if (g !== {1'b1, 128'hCAFEF00D_80000000_00000000_00000020}) begin
        bad++; $display("FAIL reset_midmsg: got last=%0b data=%h required last=1 data=cafef00d800000000000000000000020",
                        g[BLOCK_W], g[BLOCK_W-1:0]);
      end
    end
    repeat (5) @(negedge clk);
    total++;
    if (got_q.size() != 0) begin bad++; $display("FAIL reset_extra: got %0d extra blocks required 0", got_q.size()); end
  endtask

  task automatic test_sweep();
    rdy_mode = 1;
    gap_max  = 2;
    for (int nw = 1; nw <= 8; nw++) begin
      for (int nb = 0; nb < 4; nb++) begin
        msg_words.delete();
        for (int i = 0; i < nw; i++) msg_words.push_back($urandom);
        msg_nb = 2'(nb);
        run_msg($sformatf("sweep_w%0d_nb%0d", nw, nb));
      end
    end
  endtask

  task automatic test_random();
    rdy_mode = 1;
    gap_max  = 3;
    for (int m = 0; m < 25; m++) begin
      msg_words.delete();
      repeat ($urandom_range(1, 12)) msg_words.push_back($urandom);
      msg_nb = 2'($urandom_range(0, 3));
      run_msg($sformatf("random_m%0d", m));
    end
    rdy_mode = 0;
    repeat (10) @(negedge clk);
    total++;
    if (got_q.size() != 0) begin bad++; $display("FAIL random_extra: got %0d extra blocks required 0", got_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_partial();
    test_back_to_back();
    test_slot3_partial();
    test_backpressure();
    test_reset_midmsg();
    test_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/msg_block_padder.md
MSG_BLOCK_PADDER -- requirements
Module: msg_block_padder

Interface
REQ-001 Parameter: PAD_BYTE, default 8'h80, end-of-message marker byte.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  input word present.
REQ-005 in_ready  output  1  word accepted when in_valid && in_ready.
REQ-006 in_data  input  32  message word; byte0 = [31:24].
REQ-007 in_last  input  1  word is the final message word.
REQ-008 in_nbytes  input  2  valid bytes in the final word (0 means 4); ignored unless in_last; non-last words are always 4 bytes.
REQ-009 out_valid  output  1  128-bit block present for the downstream hash stage.
REQ-010 out_ready  input  1  block consumed when out_valid && out_ready.
REQ-011 out_data  output  128  block; word0 = [127:96], word3 = [31:0].
REQ-012 out_last  output  1  block is the final padded block of the message.

Function
REQ-013 Accepted words shall fill word slots 0..3 in order; the slot index wraps 3->0 after a block is emitted.
REQ-014 The length counter shall add 8*bytes per accepted word and wrap modulo 2^32; the final length equals total message bits.
REQ-015 The final word with k<4 bytes shall keep its top k bytes, place PAD_BYTE in byte k, and zero the remaining bytes.
REQ-016 Final word with k=4 shall place PAD_BYTE in byte0 of the next slot.
REQ-017 All unused slots shall be zero; the 32-bit length shall occupy word3 of the final block.
REQ-018 If the marker and data leave word3 free, one block is emitted with out_last=1.
REQ-019 Otherwise the current block is emitted with out_last=0, followed by a tail block {T,0,0,len} with out_last=1. T=PAD_BYTE<<24 only when the final full word sat in slot 3; otherwise T=0.
REQ-020 FSM states: S_ACCUM, S_OUT, S_OUT_TAIL.
REQ-021 S_ACCUM: in_ready=1; a 4th word or a final word loads out_data, sets out_valid the next cycle, and moves to S_OUT, or to S_OUT_TAIL if a tail block is needed.
REQ-022 S_OUT: in_ready=0. On out_ready, out_valid clears next cycle and the FSM returns to S_ACCUM. If out_last was 1, the slot index and length clear.
REQ-023 S_OUT_TAIL: in_ready=0. On out_ready, the tail block loads with out_valid held at 1 (back-to-back) and the FSM moves to S_OUT.
REQ-024 out_data and out_last shall stay stable while out_valid && !out_ready.
REQ-025 Latency: out_valid rises exactly one cycle after the completing input handshake.
REQ-026 Empty messages are unsupported; every message has at least 1 byte.

Reset
REQ-027 When rst is high at a clock edge: FSM goes to S_ACCUM; slot index=0, length=0, out_valid=0, out_last=0, out_data=0.
REQ-028 in_ready shall be 0 while rst is high.
REQ-029 A partial message or pending block at reset shall be discarded.

Structure
REQ-030 A shared package holds the FSM state enum, WORD_W=32, BLOCK_W=128, LEN_W=32, and the PAD_BYTE default.
REQ-031 One sub-module, msg_pad_word: combinational byte mask plus marker insertion for a single word.

Verification
REQ-032 Input 0xDEADBEEF, last, nbytes=2 -> one block 0xDEAD8000_00000000_00000000_00000010, out_last=1.
REQ-033 Three full words A,B,C, C last -> block {A,B,C,0x80000000} out_last=0, then {0,0,0,0x00000060} out_last=1, back-to-back.
REQ-034 Three full words, then 0x11223344 last nbytes=1 -> block {w0,w1,w2,0x11800000} out_last=0, then {0,0,0,0x00000068} out_last=1.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles -> out_data and out_last unchanged, in_ready=0 throughout, and no input accepted.
REQ-036 Reset after 2 accepted words, then 0xCAFEF00D last nbytes=0 -> block {0xCAFEF00D,0x80000000,0,0x00000020}; no residue from the earlier words.
